// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-side 128-bit block memory interface.
package mem_if_pkg;

  localparam int unsigned MEM_BLK_W  = 128;
  localparam int unsigned MEM_ADDR_W = 28;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/mem_block_responder_blk_ram.sv
// Single-port block array: synchronous write, registered read whose output holds until the next read.
module blk_ram #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [BLK_W-1:0] wdata,
  output logic [BLK_W-1:0] rdata
);

  logic [BLK_W-1:0] mem [2**IDX_W];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_block_responder.sv
// Memory-side responder: accepts a held block request, services it after LATENCY edges, pulses mem_ready.
module mem_block_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned BLK_W   = 128
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [BLK_W-1:0]      mem_wdata,
  output logic [BLK_W-1:0]      mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_block_responder: LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  op_t              op_q, op_nxt, op_fire;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [BLK_W-1:0] wdata_q, wdata_nxt;
  logic             ready_q, ready_nxt;
  logic             err_q, err_nxt;
  logic             fire;
  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_addr;
  logic [BLK_W-1:0] ram_wdata;
  logic             req;

  assign req = mem_read | mem_write;

  // The access happens on the edge where the counter reaches zero, so ready
  // follows acceptance by LATENCY-1 edges; LATENCY=1 fires on the acceptance edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    idx_nxt   = idx_q;
    wdata_nxt = wdata_q;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    fire      = 1'b0;
    op_fire   = op_q;
    ram_addr  = idx_q;
    ram_wdata = wdata_q;

    unique case (state)
      S_IDLE: begin
        if (req) begin
          op_nxt    = mem_write ? OP_WR : OP_RD;
          idx_nxt   = mem_addr[IDX_W-1:0];
          wdata_nxt = mem_wdata;
          cnt_nxt   = CNT_LOAD;
          err_nxt   = mem_read & mem_write;
          if (CNT_LOAD == '0) begin
            fire      = 1'b1;
            op_fire   = op_nxt;
            ram_addr  = mem_addr[IDX_W-1:0];
            ram_wdata = mem_wdata;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          fire      = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: state_nxt = S_HOLD;
      S_HOLD: if (!req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt = fire;
    ram_we    = fire && (op_fire == OP_WR) && !proc_reset;
    ram_re    = fire && (op_fire == OP_RD);
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= ready_nxt;
      err_q   <= err_nxt;
      op_q    <= op_nxt;
      idx_q   <= idx_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  blk_ram #(
    .IDX_W(IDX_W),
    .BLK_W(BLK_W)
  ) u_ram (
    .clk  (clk),
    .rst  (proc_reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(mem_rdata)
  );

  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench: randomized block requests against an array model; a LATENCY=1 instance checks the fast path.
module tb_mem_block_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready, mem_err;

  logic         rst1, rd1, wr1;
  logic [27:0]  addr1;
  logic [127:0] wdata1, rdata1;
  logic         ready1, err1;

  always #5 clk = ~clk;

  mem_block_responder #(.LATENCY(LAT), .IDX_W(8), .BLK_W(128)) u_dut (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err)
  );

  mem_block_responder #(.LATENCY(1), .IDX_W(8), .BLK_W(128)) u_dut1 (
    .clk(clk), .proc_reset(rst1), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
    .mem_ready(ready1), .mem_err(err1)
  );

  typedef struct {
    bit           wr;
    bit           err;
    logic [7:0]   idx;
    logic [127:0] wd;
    int           acc;
    int           rdy;
  } txn_t;

  txn_t         exp_q[$];
  logic [127:0] ref_mem [256];
  logic [127:0] model_rdata;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  bit           mon_en = 1'b0;
  bit           done1 = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (proc_reset) begin
      exp_q.delete();
      model_rdata = '0;
    end
  end

  // Monitor: expected response is owned by the head of the queue.
  always @(negedge clk) begin
    bit exp_rdy, exp_err;
    txn_t t;
    if (mon_en) begin
      exp_rdy = (exp_q.size() != 0) && (exp_q[0].rdy == cyc);
      exp_err = (exp_q.size() != 0) && exp_q[0].err && (exp_q[0].acc == cyc);
      if (exp_rdy) begin
        t = exp_q.pop_front();
        if (t.wr) ref_mem[t.idx] = t.wd;
        else      model_rdata = ref_mem[t.idx];
      end
      check("mem_ready", 128'(mem_ready), 128'(exp_rdy));
      check("mem_err",   128'(mem_err),   128'(exp_err));
      check("mem_rdata", mem_rdata, model_rdata);
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 128'(0), 128'(1));
  endtask

  // Caller is at a negedge with the responder idle.
  task automatic issue(input bit rd, input bit wr, input logic [27:0] addr,
                       input logic [127:0] wd, input int hold);
    txn_t t;
    bit ok;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wd;
    t.wr  = wr;
    t.err = rd & wr;
    t.idx = addr[7:0];
    t.wd  = wd;
    t.acc = cyc + 1;
    t.rdy = cyc + LAT;
    exp_q.push_back(t);
    wait_ready(ok);
    repeat (hold) @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = $urandom();
    mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] pre5;
    txn_t t;
    int   hold;
    bit   rd, wr;
    logic [7:0] idx;
    pre5 = 128'h0123456789ABCDEF0123456789ABCDEF;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i == 5) v = pre5;
      if (i == 3) v = {32{4'h1}};
      ref_mem[i] = v;
      u_dut.u_ram.mem[i] = v;
    end
    proc_reset = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    model_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_rdata", mem_rdata, 128'd0);
    check("reset_ready", 128'(mem_ready), 128'd0);
    check("reset_err",   128'(mem_err),   128'd0);
    mon_en = 1'b1;
    proc_reset = 1'b0;
    @(negedge clk);

    // Preloaded read, held three cycles past ready.
    issue(1'b1, 1'b0, 28'h0000005, '0, 3);
    check("preload_read", mem_rdata, pre5);
    // Write then read back the same block.
    issue(1'b0, 1'b1, 28'h0000010, {32{4'hA}}, 0);
    issue(1'b1, 1'b0, 28'h0000010, '0, 1);
    check("write_readback", mem_rdata, {32{4'hA}});
    // Both requests high: treated as a write, error pulse.
    issue(1'b1, 1'b1, 28'h0000007, {32{4'h5}}, 0);
    issue(1'b1, 1'b0, 28'h0000007, '0, 0);
    check("both_high_write", mem_rdata, {32{4'h5}});

    // Reset one edge before the write would commit.
    mem_write = 1'b1;
    mem_addr  = 28'h0000003;
    mem_wdata = {32{4'hE}};
    t.wr = 1'b1; t.err = 1'b0; t.idx = 8'h03; t.wd = {32{4'hE}};
    t.acc = cyc + 1; t.rdy = cyc + LAT;
    exp_q.push_back(t);
    repeat (LAT - 1) @(negedge clk);
    proc_reset = 1'b1;
    @(negedge clk);
    check("abort_rdata", mem_rdata, 128'd0);
    check("abort_ready", 128'(mem_ready), 128'd0);
    proc_reset = 1'b0;
    mem_write  = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b0, 28'h0000003, '0, 0);
    check("abort_not_committed", mem_rdata, {32{4'h1}});

    for (int n = 0; n < 60; n++) begin
      idx  = 8'($urandom_range(0, 15));
      rd   = ($urandom_range(0, 1) == 0);
      wr   = !rd;
      if ($urandom_range(0, 7) == 0) begin rd = 1'b1; wr = 1'b1; end
      hold = $urandom_range(0, 3);
      issue(rd, wr, {20'($urandom()), idx}, {$urandom(), $urandom(), $urandom(), $urandom()}, hold);
    end

    for (int n = 0; n < 200 && !done1; n++) @(negedge clk);
    if (!done1) check("lat1_done", 128'(0), 128'(1));
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // LATENCY=1 instance: aliased address, ready one edge after request.
  initial begin
    int  acc;
    bit  ok;
    logic [127:0] pre2;
    pre2 = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    u_dut1.u_ram.mem[2] = pre2;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    rd1   = 1'b1;
    addr1 = 28'h0FFFF02;
    acc   = cyc + 1;
    ok    = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready1) begin ok = 1'b1; break; end
    end
    check("lat1_ready_seen", 128'(ok), 128'd1);
    check("lat1_ready_cycle", 128'(cyc), 128'(acc));
    check("lat1_alias_data", rdata1, pre2);
    check("lat1_err", 128'(err1), 128'd0);
    rd1 = 1'b0;
    @(negedge clk);
    check("lat1_single_pulse", 128'(ready1), 128'd0);
    done1 = 1'b1;
  end

endmodule
